enemy_march_ctrl: RTL
=====================

ENEMY_MARCH_CTRL -- requirements
Module: enemy_march_ctrl

Interface
REQ-001 Parameter STEP_X, default 1: pixels moved per horizontal step, used for edge prediction.
REQ-002 Parameter SCREEN_LEFT, default 10'd0: leftmost legal fleet x.
REQ-003 Parameter SCREEN_RIGHT, default 10'd639: rightmost legal fleet x.
REQ-004 Parameter BOTTOM_LIMIT, default 10'd440: fleet_bottom_y at or beyond which the fleet has landed.
REQ-005 Parameter PERIOD_MIN, default 2: fastest step period in frames.
REQ-006 Parameter PERIOD_MAX, default 55: slowest step period in frames.
REQ-007 frame_clk  in  1  the single clock, one edge per video frame.
REQ-008 Reset_n  in  1  asynchronous, active-low reset.
REQ-009 game_start  in  1  one-cycle pulse that starts or restarts a wave.
REQ-010 pause  in  1  level; freezes the march while high.
REQ-011 fleet_left_x, fleet_right_x, fleet_bottom_y  in  10 each  live bounding box of the surviving enemies.
REQ-012 enemies_alive  in  6  count of surviving enemies, 0..55.
REQ-013 step_en  out  1  one-cycle pulse; enemies move only on this cycle.
REQ-014 enemy_direction_X  out  1  0 = move left, 1 = move right.
REQ-015 enemy_direction_Y  out  1  1 = move down on this step, 0 = stay; high only together with step_en.
REQ-016 fleet_landed  out  1  sticky loss flag.
REQ-017 wave_cleared  out  1  one-cycle pulse when the last enemy dies.
REQ-018 march_state  out  3  current state, encoded as march_state_t.

Function
REQ-019 States SHALL be IDLE, MARCH, DROP, LANDED and CLEARED.
REQ-020 IDLE SHALL go to MARCH on game_start, with enemy_direction_X=0 and the period counter loaded.
REQ-021 In MARCH the period counter SHALL decrement once per frame_clk while pause=0, and SHALL hold while pause=1.
REQ-022 When the counter reaches 0 and the next step would cross an edge, the block SHALL go to DROP without issuing step_en.
- Right edge: direction right and fleet_right_x+STEP_X > SCREEN_RIGHT.
- Left edge: direction left and fleet_left_x < SCREEN_LEFT+STEP_X.
REQ-023 When the counter reaches 0 and no edge would be crossed, the block SHALL pulse step_en for one cycle with enemy_direction_Y=0 and reload the counter.
REQ-024 DROP SHALL last exactly one cycle.
- Outputs: step_en=1, enemy_direction_Y=1, enemy_direction_X inverted on the same cycle.
- Then: counter reloaded and return to MARCH.
REQ-025 The reload value SHALL be enemies_alive clamped to [PERIOD_MIN, PERIOD_MAX], sampled at reload time.
REQ-026 In MARCH or DROP, fleet_bottom_y >= BOTTOM_LIMIT SHALL go to LANDED and set fleet_landed.
REQ-027 In MARCH or DROP, enemies_alive==0 SHALL go to CLEARED with a one-cycle wave_cleared pulse.
REQ-028 If the landed and cleared conditions occur on the same cycle, CLEARED SHALL take priority.
REQ-029 LANDED and CLEARED SHALL issue no step_en and SHALL leave only on game_start (to MARCH) or reset.
REQ-030 game_start in any state SHALL restart the wave: fleet_landed cleared, direction left, counter reloaded, state MARCH.
REQ-031 Edge tests SHALL use 11-bit arithmetic so that right_x+STEP_X cannot wrap.
REQ-032 pause SHALL not block the LANDED/CLEARED checks.

Reset
REQ-033 Reset_n=0 SHALL force, asynchronously: state IDLE, counter 0, step_en=0, enemy_direction_X=0, enemy_direction_Y=0, fleet_landed=0, wave_cleared=0.
REQ-034 A reset mid-DROP SHALL abort the step; no step_en pulse SHALL follow reset release until game_start.

Configuration
REQ-035 With MARCH_SPEEDUP_EN defined, the reload value SHALL be as in REQ-025.
REQ-036 With MARCH_SPEEDUP_EN undefined, the reload value SHALL be PERIOD_MAX at all times and enemies_alive SHALL affect only the clear detection.

Structure
REQ-037 march_state_t and the screen constants SHALL live in shared package space_invaders_pkg.
REQ-038 The period down-counter SHALL be sub-module march_step_timer, with load, enable, load value and zero flag.

Verification
REQ-039 Reset, game_start, alive=55, no edges: step_en exactly every 55 frames, enemy_direction_X=0, enemy_direction_Y=0.
REQ-040 Direction left, fleet_left_x=0, counter expiry: one DROP step with step_en=1 and enemy_direction_Y=1, enemy_direction_X goes 0->1 on the same cycle, then MARCH.
REQ-041 alive drops 55->1 mid-wave with MARCH_SPEEDUP_EN defined: next period is 2 frames; without the macro it stays 55.
REQ-042 fleet_bottom_y=440 and enemies_alive=0 on the same cycle: CLEARED, wave_cleared pulses once, fleet_landed stays 0.
REQ-043 pause held for 10 frames mid-period: step_en is delayed by exactly 10 frames.
REQ-044 Reset_n asserted during DROP, then released: IDLE, all outputs 0, no step_en until game_start.

Source files
------------

// File: rtl/space_invaders_pkg.sv
// rtl/space_invaders_pkg.sv - shared march state encoding, screen constants and period clamp helper
package space_invaders_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MARCH   = 3'd1,
    ST_DROP    = 3'd2,
    ST_LANDED  = 3'd3,
    ST_CLEARED = 3'd4
  } march_state_t;

  localparam logic [9:0] SCREEN_LEFT_DEF  = 10'd0;
  localparam logic [9:0] SCREEN_RIGHT_DEF = 10'd639;
  localparam logic [9:0] BOTTOM_LIMIT_DEF = 10'd440;
  localparam int         PERIOD_MIN_DEF   = 2;
  localparam int         PERIOD_MAX_DEF   = 55;
  localparam int         TIMER_W          = 6;

  // Step period follows the surviving enemy count, bounded so the fleet never stalls or blurs
  function automatic logic [5:0] clamp_period(input logic [5:0] alive,
                                              input logic [5:0] lo,
                                              input logic [5:0] hi);
    if (alive < lo) return lo;
    else if (alive > hi) return hi;
    else return alive;
  endfunction

endpackage

// File: rtl/march_step_timer.sv
// rtl/march_step_timer.sv - loadable frame down-counter that flags when the step period has elapsed
module march_step_timer #(
  parameter int W = 6
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  // Load wins over counting; the counter parks at zero until reloaded
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Counter register, cleared to zero by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/enemy_march_ctrl.sv
// rtl/enemy_march_ctrl.sv - fleet march sequencer (step, edge drop, land, clear); MARCH_SPEEDUP_EN enables alive-count speedup
module enemy_march_ctrl
  import space_invaders_pkg::*;
#(
  parameter int         STEP_X       = 1,
  parameter logic [9:0] SCREEN_LEFT  = SCREEN_LEFT_DEF,
  parameter logic [9:0] SCREEN_RIGHT = SCREEN_RIGHT_DEF,
  parameter logic [9:0] BOTTOM_LIMIT = BOTTOM_LIMIT_DEF,
  parameter int         PERIOD_MIN   = PERIOD_MIN_DEF,
  parameter int         PERIOD_MAX   = PERIOD_MAX_DEF
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       game_start,
  input  logic       pause,
  input  logic [9:0] fleet_left_x,
  input  logic [9:0] fleet_right_x,
  input  logic [9:0] fleet_bottom_y,
  input  logic [5:0] enemies_alive,
  output logic       step_en,
  output logic       enemy_direction_X,
  output logic       enemy_direction_Y,
  output logic       fleet_landed,
  output logic       wave_cleared,
  output logic [2:0] march_state
);

  localparam logic [5:0] PMIN = 6'(PERIOD_MIN);
  localparam logic [5:0] PMAX = 6'(PERIOD_MAX);

  march_state_t state_q;
  logic         step_en_q, dir_x_q, dir_y_q, landed_q, cleared_q;

  logic [5:0]   period;
  logic [5:0]   load_val;
  logic [10:0]  right_next;
  logic [10:0]  left_limit;
  logic         edge_hit, cleared_hit, landed_hit;
  logic         timer_zero, timer_load, timer_en, march_tick;

`ifdef MARCH_SPEEDUP_EN
  assign period = clamp_period(enemies_alive, PMIN, PMAX);
`else
  assign period = PMAX;
`endif

  // The timer counts period-1 down to zero so that a step fires every 'period' frames
  assign load_val = period - 6'd1;

  // 11-bit sums keep right_x + STEP_X from wrapping past 1023
  assign right_next = {1'b0, fleet_right_x} + 11'(STEP_X);
  assign left_limit = {1'b0, SCREEN_LEFT} + 11'(STEP_X);
  assign edge_hit   = dir_x_q ? (right_next > {1'b0, SCREEN_RIGHT})
                              : ({1'b0, fleet_left_x} < left_limit);

  assign cleared_hit = (enemies_alive == 6'd0);
  assign landed_hit  = (fleet_bottom_y >= BOTTOM_LIMIT);
  assign march_tick  = (state_q == ST_MARCH) && timer_zero && !pause;

  assign timer_en   = (state_q == ST_MARCH) && !pause;
  assign timer_load = game_start ||
                      (!cleared_hit && !landed_hit &&
                       ((state_q == ST_DROP) || (march_tick && !edge_hit)));

  march_step_timer #(.W(TIMER_W)) u_timer (
    .clk_i      (frame_clk),
    .rst_ni     (Reset_n),
    .load_i     (timer_load),
    .en_i       (timer_en),
    .load_val_i (load_val),
    .zero_o     (timer_zero)
  );

  // March sequencer with registered outputs; game_start overrides every state
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      step_en_q <= 1'b0;
      dir_x_q   <= 1'b0;
      dir_y_q   <= 1'b0;
      landed_q  <= 1'b0;
      cleared_q <= 1'b0;
    end else begin
      step_en_q <= 1'b0;
      dir_y_q   <= 1'b0;
      cleared_q <= 1'b0;
      if (game_start) begin
        state_q  <= ST_MARCH;
        dir_x_q  <= 1'b0;
        landed_q <= 1'b0;
      end else begin
        case (state_q)
          ST_MARCH, ST_DROP: begin
            if (cleared_hit) begin
              state_q   <= ST_CLEARED;
              cleared_q <= 1'b1;
            end else if (landed_hit) begin
              state_q  <= ST_LANDED;
              landed_q <= 1'b1;
            end else if (state_q == ST_DROP) begin
              state_q <= ST_MARCH;
            end else if (march_tick) begin
              step_en_q <= 1'b1;
              if (edge_hit) begin
                state_q <= ST_DROP;
                dir_y_q <= 1'b1;
                dir_x_q <= ~dir_x_q;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign step_en           = step_en_q;
  assign enemy_direction_X = dir_x_q;
  assign enemy_direction_Y = dir_y_q;
  assign fleet_landed      = landed_q;
  assign wave_cleared      = cleared_q;
  assign march_state       = state_q;

endmodule
